// File: rtl/psum_mem_arbiter.sv
// Single-port psum SRAM arbiter for OFIFO drain, SFU and host readout, with starvation promotion and SFU lock.
// Grants are same-cycle combinational, read data returns one cycle later, and a requester holds its request until granted.
module psum_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 104,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              of_req,
  input  logic [ADDR_W-1:0] of_addr,
  input  logic [DATA_W-1:0] of_wdata,
  output logic              of_gnt,
  input  logic              sfu_req,
  input  logic              sfu_we,
  input  logic              sfu_lock,
  input  logic [ADDR_W-1:0] sfu_addr,
  input  logic [DATA_W-1:0] sfu_wdata,
  output logic              sfu_gnt,
  output logic              sfu_rvalid,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q,
  output logic              starve_err
);

  typedef enum logic {ARB, SFU_LOCK} state_t;

  localparam logic [7:0] PROMOTE_LVL = 8'(STARVE_MAX);
  localparam logic [8:0] ERR_LVL     = 9'(2 * STARVE_MAX);

  state_t              state;
  logic [7:0]          of_wait, sfu_wait, host_wait;
  logic [7:0]          of_wait_nxt, sfu_wait_nxt, host_wait_nxt;
  logic                of_prom, sfu_prom, host_prom;
  logic                of_g, sfu_g, host_g;
  logic                sfu_rd_q, host_rd_q, starve_q;
  logic                rv_any;
  logic [ADDR_W-1:0]   a_q, a_mux;
  logic [DATA_W-1:0]   d_q, d_mux, rdata_q;

  function automatic logic [7:0] wait_next(input logic req, input logic gnt, input logic [7:0] cur);
    if (!req || gnt)
      return 8'd0;
    else if (cur == 8'hFF)
      return cur;
    else
      return cur + 8'd1;
  endfunction

  assign of_prom   = of_req   && (of_wait   >= PROMOTE_LVL);
  assign sfu_prom  = sfu_req  && (sfu_wait  >= PROMOTE_LVL);
  assign host_prom = host_req && (host_wait >= PROMOTE_LVL);

  // Promoted requesters win first, ordered among themselves by base priority.
  always_comb begin
    of_g   = 1'b0;
    sfu_g  = 1'b0;
    host_g = 1'b0;
    if (!reset) begin
      if (state == SFU_LOCK)  sfu_g  = sfu_req;
      else if (of_prom)       of_g   = 1'b1;
      else if (sfu_prom)      sfu_g  = 1'b1;
      else if (host_prom)     host_g = 1'b1;
      else if (of_req)        of_g   = 1'b1;
      else if (sfu_req)       sfu_g  = 1'b1;
      else if (host_req)      host_g = 1'b1;
    end
  end

  assign of_wait_nxt   = wait_next(of_req,   of_g,   of_wait);
  assign sfu_wait_nxt  = wait_next(sfu_req,  sfu_g,  sfu_wait);
  assign host_wait_nxt = wait_next(host_req, host_g, host_wait);

  // The host has no write data, so D keeps its previous value on a host grant.
  always_comb begin
    a_mux = a_q;
    d_mux = d_q;
    if (of_g) begin
      a_mux = of_addr;
      d_mux = of_wdata;
    end else if (sfu_g) begin
      a_mux = sfu_addr;
      d_mux = sfu_wdata;
    end else if (host_g) begin
      a_mux = host_addr;
    end
  end

  assign rv_any = (sfu_rd_q | host_rd_q) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      of_wait   <= '0;
      sfu_wait  <= '0;
      host_wait <= '0;
      starve_q  <= 1'b0;
      sfu_rd_q  <= 1'b0;
      host_rd_q <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
      rdata_q   <= '0;
    end else begin
      of_wait   <= of_wait_nxt;
      sfu_wait  <= sfu_wait_nxt;
      host_wait <= host_wait_nxt;
      if (({1'b0, of_wait_nxt} >= ERR_LVL) || ({1'b0, sfu_wait_nxt} >= ERR_LVL) ||
          ({1'b0, host_wait_nxt} >= ERR_LVL))
        starve_q <= 1'b1;
      case (state)
        ARB:      if (sfu_g && sfu_lock) state <= SFU_LOCK;
        SFU_LOCK: if (!sfu_lock)         state <= ARB;
        default:                         state <= ARB;
      endcase
      sfu_rd_q  <= sfu_g && !sfu_we;
      host_rd_q <= host_g;
      a_q       <= a_mux;
      d_q       <= d_mux;
      if (rv_any) rdata_q <= Q;
    end
  end

  assign of_gnt      = of_g;
  assign sfu_gnt     = sfu_g;
  assign host_gnt    = host_g;
  assign sfu_rvalid  = sfu_rd_q  & ~reset;
  assign host_rvalid = host_rd_q & ~reset;
  assign rdata       = reset ? '0 : (rv_any ? Q : rdata_q);
  assign CEN         = ~(of_g | sfu_g | host_g);
  assign WEN         = ~(of_g | (sfu_g & sfu_we));
  assign A           = reset ? '0 : a_mux;
  assign D           = reset ? '0 : d_mux;
  assign starve_err  = starve_q & ~reset;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Bench for psum_mem_arbiter: SRAM model, per-cycle reference arbiter and directed scenarios.
module tb_psum_mem_arbiter;
  localparam int AW = 11;
  localparam int DW = 104;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          of_req, sfu_req, sfu_we, sfu_lock, host_req;
  logic [AW-1:0] of_addr, sfu_addr, host_addr;
  logic [DW-1:0] of_wdata, sfu_wdata;
  logic          of_gnt, sfu_gnt, host_gnt, sfu_rvalid, host_rvalid;
  logic [DW-1:0] rdata, D, q;
  logic          CEN, WEN, starve_err;
  logic [AW-1:0] A;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  psum_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .of_req(of_req), .of_addr(of_addr), .of_wdata(of_wdata), .of_gnt(of_gnt),
    .sfu_req(sfu_req), .sfu_we(sfu_we), .sfu_lock(sfu_lock), .sfu_addr(sfu_addr),
    .sfu_wdata(sfu_wdata), .sfu_gnt(sfu_gnt), .sfu_rvalid(sfu_rvalid),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .rdata(rdata), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(q), .starve_err(starve_err)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM.
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) mem[A] = D;
      else      q <= mem[A];
    end
  end

  // Reference model: index 0 = OFIFO, 1 = SFU, 2 = host.
  int            mw [3];
  bit            mlock, merr, pv_s, pv_h;
  logic [DW-1:0] pdata = '0, rd_hold = '0, dhold = '0;
  logic [AW-1:0] ahold = '0;

  function automatic int winner();
    bit rq [3];
    rq[0] = of_req; rq[1] = sfu_req; rq[2] = host_req;
    if (reset) return -1;
    if (mlock) return sfu_req ? 1 : -1;
    for (int i = 0; i < 3; i++) if (rq[i] && mw[i] >= SM) return i;
    for (int i = 0; i < 3; i++) if (rq[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int  win;
    bit  rq [3];
    win = winner();
    rq[0] = of_req; rq[1] = sfu_req; rq[2] = host_req;
    if (reset) begin
      for (int i = 0; i < 3; i++) mw[i] = 0;
      mlock = 0; merr = 0; pv_s = 0; pv_h = 0;
      pdata = '0; rd_hold = '0; ahold = '0; dhold = '0;
    end else begin
      if (pv_s || pv_h) rd_hold = pdata;
      pv_s = (win == 1) && !sfu_we;
      pv_h = (win == 2);
      if (pv_s) pdata = mem[sfu_addr];
      if (pv_h) pdata = mem[host_addr];
      for (int i = 0; i < 3; i++) begin
        if (!rq[i] || win == i) mw[i] = 0;
        else if (mw[i] < 255)   mw[i] = mw[i] + 1;
        if (mw[i] >= 2 * SM) merr = 1;
      end
      mlock = mlock ? sfu_lock : (win == 1 && sfu_lock);
      if (win == 0) begin ahold = of_addr; dhold = of_wdata; end
      if (win == 1) begin ahold = sfu_addr; dhold = sfu_wdata; end
      if (win == 2) ahold = host_addr;
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int            w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (chk_en) begin
      w  = winner();
      ea = (w == 0) ? of_addr : (w == 1) ? sfu_addr : (w == 2) ? host_addr : ahold;
      ed = (w == 0) ? of_wdata : (w == 1) ? sfu_wdata : dhold;
      chk("m_of_gnt", of_gnt, w == 0);
      chk("m_sfu_gnt", sfu_gnt, w == 1);
      chk("m_host_gnt", host_gnt, w == 2);
      chk("m_CEN", CEN, w < 0);
      chk("m_WEN", WEN, !(w == 0 || (w == 1 && sfu_we)));
      chk("m_A", A, reset ? '0 : ea);
      chk("m_D", D, reset ? '0 : ed);
      chk("m_sfu_rvalid", sfu_rvalid, pv_s && !reset);
      chk("m_host_rvalid", host_rvalid, pv_h && !reset);
      chk("m_rdata", rdata, reset ? '0 : ((pv_s || pv_h) ? pdata : rd_hold));
      chk("m_starve_err", starve_err, merr && !reset);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[11'h005] = 104'hABC;
    mem[11'h020] = 104'h1234;
    q = '0;
    reset = 1'b1;
    of_req = 0; sfu_req = 0; sfu_we = 0; sfu_lock = 0; host_req = 0;
    of_addr = '0; sfu_addr = '0; host_addr = '0; of_wdata = '0; sfu_wdata = '0;
    tick();
    chk_en = 1'b1;
    mid();
    chk("rst_CEN", CEN, 1); chk("rst_WEN", WEN, 1); chk("rst_A", A, 0);
    chk("rst_D", D, 0); chk("rst_rdata", rdata, 0); chk("rst_err", starve_err, 0);
    tick();
    of_req = 1; host_req = 1;
    mid();
    chk("rst_of_gnt", of_gnt, 0); chk("rst_host_gnt", host_gnt, 0); chk("rst_CEN_req", CEN, 1);
    tick();
    reset = 0; of_req = 0; host_req = 0;

    // Host read on an idle arbiter.
    host_req = 1; host_addr = 11'h005;
    mid();
    chk("h_gnt", host_gnt, 1); chk("h_CEN", CEN, 0); chk("h_WEN", WEN, 1); chk("h_A", A, 11'h005);
    tick();
    host_req = 0;
    mid();
    chk("h_rvalid", host_rvalid, 1); chk("h_rdata", rdata, 104'hABC);
    tick();
    mid();
    chk("h_rvalid_off", host_rvalid, 0); chk("h_rdata_hold", rdata, 104'hABC);
    tick();

    // OFIFO vs SFU conflict; a lock request from the losing SFU must not engage.
    of_req = 1; of_addr = 11'h010; of_wdata = 104'h55;
    sfu_req = 1; sfu_we = 0; sfu_addr = 11'h020; sfu_lock = 1;
    mid();
    chk("c_of_gnt", of_gnt, 1); chk("c_sfu_gnt", sfu_gnt, 0); chk("c_WEN", WEN, 0);
    chk("c_A", A, 11'h010); chk("c_D", D, 104'h55);
    tick();
    of_req = 0; sfu_lock = 0;
    mid();
    chk("c_sfu_gnt2", sfu_gnt, 1); chk("c_A2", A, 11'h020); chk("c_WEN2", WEN, 1);
    tick();
    sfu_req = 0; of_req = 1; of_addr = 11'h012; of_wdata = 104'h66;
    mid();
    chk("c_sfu_rvalid", sfu_rvalid, 1); chk("c_rdata", rdata, 104'h1234); chk("c_of_after", of_gnt, 1);
    tick();
    of_req = 0; host_req = 1; host_addr = 11'h010;
    mid();
    chk("c_host_gnt", host_gnt, 1);
    tick();
    host_req = 0;
    mid();
    chk("c_written", rdata, 104'h55);
    tick();

    // Starvation promotion of the host under continuous OFIFO traffic.
    of_req = 1; of_addr = 11'h040; of_wdata = 104'h1; host_req = 1; host_addr = 11'h005;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("s_of_gnt", of_gnt, 1); chk("s_host_wait", host_gnt, 0);
      tick();
    end
    mid();
    chk("s_host_gnt", host_gnt, 1); chk("s_of_denied", of_gnt, 0); chk("s_err", starve_err, 0);
    tick();
    host_req = 0;
    mid();
    chk("s_of_back", of_gnt, 1); chk("s_rdata", rdata, 104'hABC);
    tick();
    of_req = 0;

    // SFU lock holds off the OFIFO until the cycle after lock drops.
    sfu_req = 1; sfu_we = 1; sfu_lock = 1; sfu_addr = 11'h030; sfu_wdata = 104'h77;
    mid();
    chk("l_sfu_gnt0", sfu_gnt, 1); chk("l_WEN0", WEN, 0);
    tick();
    for (int k = 1; k < 6; k++) begin
      if (k >= 2) begin of_req = 1; of_addr = 11'h041; end
      mid();
      chk("l_sfu_gnt", sfu_gnt, 1); chk("l_of_blocked", of_gnt, 0);
      tick();
    end
    sfu_req = 0; sfu_lock = 0;
    mid();
    chk("l_release_of", of_gnt, 0); chk("l_release_CEN", CEN, 1);
    tick();
    mid();
    chk("l_of_gnt", of_gnt, 1); chk("l_err", starve_err, 0);
    tick();
    of_req = 0;

    // Long lock starves the host; the error flag is sticky.
    sfu_req = 1; sfu_we = 0; sfu_lock = 1; sfu_addr = 11'h020; host_req = 1; host_addr = 11'h005;
    for (int k = 0; k < 7; k++) begin
      mid();
      chk("e_sfu_gnt", sfu_gnt, 1); chk("e_host_gnt", host_gnt, 0);
      chk("e_err", starve_err, k >= 6);
      tick();
    end
    sfu_req = 0; sfu_lock = 0;
    mid();
    chk("e_still_locked", host_gnt, 0); chk("e_err_a", starve_err, 1);
    tick();
    mid();
    chk("e_host_gnt_end", host_gnt, 1); chk("e_err_b", starve_err, 1);
    tick();
    host_req = 0;
    mid();
    chk("e_err_c", starve_err, 1);
    tick();

    // Reset with a read in flight and the lock engaged.
    sfu_req = 1; sfu_we = 0; sfu_lock = 1; sfu_addr = 11'h020;
    mid();
    chk("r_sfu_gnt", sfu_gnt, 1);
    tick();
    reset = 1;
    mid();
    chk("r_rvalid", sfu_rvalid, 0); chk("r_sfu_gnt_rst", sfu_gnt, 0); chk("r_CEN", CEN, 1);
    chk("r_err_clr", starve_err, 0); chk("r_rdata", rdata, 0);
    tick();
    reset = 0; of_req = 1; of_addr = 11'h050;
    mid();
    chk("r_of_first", of_gnt, 1); chk("r_sfu_wait", sfu_gnt, 0); chk("r_rvalid2", sfu_rvalid, 0);
    tick();
    of_req = 0;
    mid();
    chk("r_sfu_next", sfu_gnt, 1);
    tick();
    sfu_req = 0; sfu_lock = 0;
    tick();
    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psum_mem_arbiter.md
PSUM_MEM_ARBITER -- requirements
Module: psum_mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 11, meaning the psum SRAM address width.
REQ-002 The module SHALL have parameter DATA_W, default 104, meaning the psum SRAM word width (psum_bw*col).
REQ-003 The module SHALL have parameter STARVE_MAX, default 15, meaning consecutive denied cycles before a requester is promoted; legal range 1..255.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- of_req  in  1  OFIFO drain request; writes only.
- of_addr  in  ADDR_W  OFIFO write address.
- of_wdata  in  DATA_W  OFIFO write data.
- of_gnt  out  1  OFIFO grant.
- sfu_req  in  1  SFU request.
- sfu_we  in  1  SFU access type; 1 = write, 0 = read.
- sfu_lock  in  1  SFU asks to keep ownership after its grant.
- sfu_addr  in  ADDR_W  SFU address.
- sfu_wdata  in  DATA_W  SFU write data.
- sfu_gnt  out  1  SFU grant.
- sfu_rvalid  out  1  SFU read data valid.
- host_req  in  1  testbench readout request; reads only.
- host_addr  in  ADDR_W  host read address.
- host_gnt  out  1  host grant.
- host_rvalid  out  1  host read data valid.
- rdata  out  DATA_W  shared read data.
- CEN  out  1  SRAM chip enable, active-low.
- WEN  out  1  SRAM write enable, active-low.
- A  out  ADDR_W  SRAM address.
- D  out  DATA_W  SRAM write data.
- Q  in  DATA_W  SRAM read data.
- starve_err  out  1  sticky starvation error flag.

Function
REQ-005 The module SHALL drive at most one grant per cycle; grants are combinational from the current request inputs and state.
REQ-006 A requester SHALL hold req, addr, we and wdata stable until the cycle in which its gnt is high; that cycle SHALL perform the access.
REQ-007 Base priority SHALL be OFIFO > SFU > host.
REQ-008 Each requester SHALL have an 8-bit wait counter:
- cleared on its grant or when its req is low;
- incremented, saturating at 255, each cycle its req is high and not granted.
REQ-009 A requester whose wait counter is >= STARVE_MAX SHALL be promoted above base priority. When several requesters are promoted, base priority SHALL order them.
REQ-010 The FSM SHALL have two states, ARB and SFU_LOCK.
REQ-011 In ARB, a cycle with sfu_gnt=1 and sfu_lock=1 SHALL move the FSM to SFU_LOCK in the next cycle.
REQ-012 In SFU_LOCK:
- only SFU SHALL be granted, whenever sfu_req=1, regardless of promotions;
- the FSM SHALL return to ARB on the first cycle sfu_lock=0.
REQ-013 While the FSM is in SFU_LOCK, other requesters' wait counters SHALL keep counting.
REQ-014 starve_err SHALL set when any wait counter reaches 2*STARVE_MAX and SHALL clear only on reset.
REQ-015 SRAM drive SHALL be:
- CEN=0 iff some grant is high;
- WEN=0 iff the granted access is a write;
- A and D SHALL come from the granted requester;
- when no requester is granted: CEN=1, WEN=1, A and D SHALL hold their last values.
REQ-016 The read path SHALL have one-cycle latency: a read granted in cycle N SHALL give rdata=Q and the matching rvalid=1 in cycle N+1 only.
REQ-017 At most one rvalid SHALL be high per cycle. rdata SHALL hold its last value when no rvalid is high.
REQ-018 An OFIFO and an SFU request in the same cycle, with neither promoted, SHALL grant OFIFO; the SFU request SHALL remain pending.
REQ-019 sfu_lock=1 while SFU is not granted SHALL have no effect.

Reset
REQ-020 While reset=1, the outputs SHALL be:
- all gnt=0 and all rvalid=0;
- CEN=1, WEN=1, A=0, D=0, rdata=0;
- starve_err=0.
REQ-021 While reset=1, the FSM SHALL be in ARB and all wait counters SHALL be 0.
REQ-022 Reset asserted mid-lock or with a read in flight SHALL abort: the pending rvalid SHALL be suppressed, and the first post-reset cycle SHALL arbitrate from base priority.

Verification
REQ-023 Host read, idle arbiter: host_req=1, host_addr=0x005, SRAM word 0xABC at that address -> host_gnt=1, CEN=0, WEN=1, A=0x005 in cycle N; host_rvalid=1, rdata=0xABC in cycle N+1.
REQ-024 Same-cycle conflict: of_req=1 addr 0x010 and sfu_req=1 read addr 0x020 -> of_gnt=1 with WEN=0, A=0x010 in cycle N; sfu_gnt=1, A=0x020 in cycle N+1; sfu_rvalid=1 in cycle N+2.
REQ-025 Starvation, STARVE_MAX=3: of_req held high continuously, host_req=1 -> host_gnt=1 after 3 denied cycles; starve_err stays 0.
REQ-026 Lock: sfu_gnt with sfu_lock=1 for 6 cycles while of_req=1 -> of_gnt=0 for those 6 cycles; of_gnt=1 on the first cycle after sfu_lock=0.
REQ-027 Lock plus starvation, STARVE_MAX=2: sfu_lock held 5 cycles while host_req=1 -> starve_err=1 when the host counter reaches 4, and it stays 1 until reset.
REQ-028 Reset mid-read: reset=1 in the cycle after an SFU read grant -> sfu_rvalid=0; FSM in ARB, all gnt=0, CEN=1.
